// File: rtl/fsbus_pkg.sv
// fsbus_pkg: shared types and helpers for the flash/SSRAM bus arbiter.
package fsbus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_HANDOFF
  } arb_state_e;

  // Widest master count the pick helper handles.
  localparam int MAX_MASTERS = 4;

  // Width of a counter that must hold values 0..max_hold.
  function automatic int hold_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

  // Cyclic one-hot priority pick: first set bit of req at or after ptr,
  // wrapping modulo n. Returns zero when nothing is requested.
  function automatic logic [3:0] rr_onehot(input logic [3:0] req,
                                           input logic [1:0] ptr,
                                           input int         n);
    logic [3:0] win;
    logic       found;
    int         idx;
    logic [1:0] idx2;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_MASTERS; k++) begin
      idx  = (int'(ptr) + k) % n;
      idx2 = idx[1:0];
      if ((k < n) && !found && req[idx2]) begin
        win[idx2] = 1'b1;
        found     = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fsbus_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder (req, ptr -> one-hot).
module rr_pick
  import fsbus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   ptr_i,
  output logic [N-1:0] gnt_o
);

  logic [3:0] req_w;
  logic [3:0] win_w;
  logic       win_unused;

  // Widen to the helper's fixed width, pick, and trim back to N masters.
  always_comb begin
    req_w          = '0;
    req_w[N-1:0]   = req_i;
    win_w          = rr_onehot(req_w, ptr_i, N);
    gnt_o          = win_w[N-1:0];
  end

  assign win_unused = ^win_w;

endmodule

// File: rtl/fsbus_arbiter.sv
// fsbus_arbiter: round-robin Wishbone arbiter with hold limit and a one-cycle
// gap between owners. Optional urgent override: define ARB_URGENT_EN.
module fsbus_arbiter
  import fsbus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int MAX_HOLD    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*32-1:0] m_dat_i,
  input  logic [NUM_MASTERS-1:0]    m_urgent_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [31:0]               m_dat_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [3:0]                s_sel_o,
  output logic [31:0]               s_dat_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  output logic [NUM_MASTERS-1:0]    gnt_o
);

  localparam int HW = hold_w(MAX_HOLD);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [1:0]             rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d, hold_inc;
  logic [1:0]             g_idx, next_ptr;
  logic [NUM_MASTERS-1:0] rr_win, idle_win, others;
  logic                   own_cyc, urgent_wait, force_off;

  rr_pick #(.N(NUM_MASTERS)) u_rr (
    .req_i (m_cyc_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_win)
  );

`ifdef ARB_URGENT_EN
  logic [NUM_MASTERS-1:0] urg_req, urg_win;
  assign urg_req = m_cyc_i & m_urgent_i;

  rr_pick #(.N(NUM_MASTERS)) u_urg (
    .req_i (urg_req),
    .ptr_i (2'd0),
    .gnt_o (urg_win)
  );

  assign idle_win    = (|urg_req) ? urg_win : rr_win;
  assign urgent_wait = |(urg_req & ~gnt_q);
`else
  logic urgent_unused;
  assign urgent_unused = ^m_urgent_i;
  assign idle_win      = rr_win;
  assign urgent_wait   = 1'b0;
`endif

  // Decode the current owner and the pointer it hands on to.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q[i]) g_idx = 2'(i);
    end
    next_ptr = (g_idx == 2'(NUM_MASTERS - 1)) ? 2'd0 : g_idx + 2'd1;
    own_cyc  = |(m_cyc_i & gnt_q);
    others   = m_cyc_i & ~gnt_q;
    hold_inc = (hold_cnt_q == HW'(MAX_HOLD)) ? hold_cnt_q : hold_cnt_q + 1'b1;
    // Preemption only lands on a beat boundary, i.e. with the ack in hand.
    force_off = s_ack_i && (|others) &&
                ((hold_inc == HW'(MAX_HOLD)) || urgent_wait);
  end

  // Next-state logic for the arbitration FSM.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (|m_cyc_i) begin
          gnt_d      = idle_win;
          hold_cnt_d = '0;
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (s_ack_i) hold_cnt_d = hold_inc;
        if (!own_cyc || force_off) begin
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
          state_d  = ARB_HANDOFF;
        end
      end
      ARB_HANDOFF: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // FSM state and registered grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Slave-side mux from the owner; everything idles low without a grant.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q[i]) begin
        s_cyc_o = m_cyc_i[i];
        s_stb_o = m_stb_i[i];
        s_we_o  = m_we_i[i];
        s_adr_o = m_adr_i[i*AW +: AW];
        s_sel_o = m_sel_i[i*4 +: 4];
        s_dat_o = m_dat_i[i*32 +: 32];
      end
    end
    // A beat cut short by reset is abandoned, so its ack is suppressed.
    m_ack_o = (state_q == ARB_GRANT && !rst_i) ?
              (gnt_q & {NUM_MASTERS{s_ack_i}}) : '0;
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_fsbus_arbiter.sv
// tb_fsbus_arbiter: table-driven cycle vectors plus hand sequences, checked
// through an expected-value queue (2 masters, MAX_HOLD=4).
module tb_fsbus_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int MH = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  m_cyc_i, m_stb_i, m_we_i, m_urgent_i, m_ack_o, gnt_o;
  logic [N*AW-1:0] m_adr_i;
  logic [N*4-1:0]  m_sel_i;
  logic [N*32-1:0] m_dat_i;
  logic [31:0]   m_dat_o, s_dat_o, s_dat_i;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [AW-1:0] s_adr_o;
  logic [3:0]    s_sel_o;

  fsbus_arbiter #(.NUM_MASTERS(N), .AW(AW), .MAX_HOLD(MH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
    .m_urgent_i(m_urgent_i), .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] cyc, stb;
    logic       ack, rst;
    logic [1:0] gnt;
    logic       scyc, sstb;
    logic [1:0] mack;
    int         sel;   // 0: no owner, 1: master 0 fields, 2: master 1 fields
  } vec_t;

  typedef struct {
    string       tag;
    int          idx;
    logic [1:0]  gnt, mack;
    logic        scyc, sstb, we;
    logic [15:0] adr;
    logic [3:0]  sel;
    logic [31:0] mdat, sdat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl [31];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input int idx, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[%0d] %s: got %h want %h", tag, idx, nm, act, req);
    end
  endtask

  task automatic step(input string tag, input int idx, input logic rst,
                      input logic [1:0] cyc, input logic [1:0] stb,
                      input logic [1:0] urg, input logic ack,
                      input logic [1:0] gnt, input logic scyc,
                      input logic sstb, input logic [1:0] mack, input int sel);
    exp_t e, g;
    @(negedge clk_i);
    rst_i = rst; m_cyc_i = cyc; m_stb_i = stb; m_urgent_i = urg;
    s_ack_i = ack; s_dat_i = $urandom;
    e.tag = tag; e.idx = idx; e.gnt = gnt; e.mack = mack;
    e.scyc = scyc; e.sstb = sstb; e.mdat = s_dat_i;
    case (sel)
      1:       begin e.adr = 16'h1000; e.we = 1'b0; e.sel = 4'h3; e.sdat = 32'hAAAA_0000; end
      2:       begin e.adr = 16'h2000; e.we = 1'b1; e.sel = 4'hC; e.sdat = 32'h5555_0001; end
      default: begin e.adr = 16'h0;    e.we = 1'b0; e.sel = 4'h0; e.sdat = 32'h0;         end
    endcase
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk(g.tag, g.idx, "gnt_o",   32'(gnt_o),   32'(g.gnt));
    chk(g.tag, g.idx, "s_cyc_o", 32'(s_cyc_o), 32'(g.scyc));
    chk(g.tag, g.idx, "s_stb_o", 32'(s_stb_o), 32'(g.sstb));
    chk(g.tag, g.idx, "m_ack_o", 32'(m_ack_o), 32'(g.mack));
    chk(g.tag, g.idx, "s_adr_o", 32'(s_adr_o), 32'(g.adr));
    chk(g.tag, g.idx, "s_we_o",  32'(s_we_o),  32'(g.we));
    chk(g.tag, g.idx, "s_sel_o", 32'(s_sel_o), 32'(g.sel));
    chk(g.tag, g.idx, "s_dat_o", s_dat_o,      g.sdat);
    chk(g.tag, g.idx, "m_dat_o", m_dat_o,      g.mdat);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; m_cyc_i = '0; m_stb_i = '0; m_urgent_i = '0; s_ack_i = 1'b0;
    @(posedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; m_cyc_i = '0; m_stb_i = '0; m_urgent_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
    m_we_i  = 2'b10;
    m_adr_i = {16'h2000, 16'h1000};
    m_sel_i = {4'hC, 4'h3};
    m_dat_i = {32'h5555_0001, 32'hAAAA_0000};

    //            cyc    stb    ack   rst   gnt    scyc  sstb  mack   sel
    tbl[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[1]  = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[2]  = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 1};
    tbl[3]  = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 1};
    tbl[4]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1};
    tbl[5]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[6]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[7]  = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[8]  = '{2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[9]  = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 1};
    tbl[10] = '{2'b10, 2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1};
    tbl[11] = '{2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[12] = '{2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[13] = '{2'b10, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2};
    tbl[14] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2};
    tbl[15] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2};
    tbl[16] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2};
    tbl[17] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[18] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[19] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 1};
    tbl[20] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 1};
    tbl[21] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 1};
    tbl[22] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 1};
    tbl[23] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[24] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[25] = '{2'b11, 2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2};
    tbl[26] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 2};
    tbl[27] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[28] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1};
    tbl[29] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};
    tbl[30] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0};

    repeat (2) @(posedge clk_i);

    for (int i = 0; i < 31; i++) begin
      step("tbl", i, tbl[i].rst, tbl[i].cyc, tbl[i].stb, 2'b00, tbl[i].ack,
           tbl[i].gnt, tbl[i].scyc, tbl[i].sstb, tbl[i].mack, tbl[i].sel);
    end

    // Lone streamer: master 1 alone keeps the bus past the hold limit; a late
    // waiter only takes over after the next completed beat.
    do_reset();
    step("lone", 0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0);
    for (int i = 1; i <= 40; i++) begin
      step("lone", i, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 2);
    end
    step("lone", 41, 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2);
    step("lone", 42, 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2);
    step("lone", 43, 1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 2);
    step("lone", 44, 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0);
    step("lone", 45, 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0);
    step("lone", 46, 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 1);

    // Urgent waiter: master 0 streams, master 1 raises cyc with urgent.
    do_reset();
    step("urg", 0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 0);
    step("urg", 1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 1);
    step("urg", 2, 1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 1);
`ifndef ARB_URGENT_EN
    step("urg", 3, 1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 1);
    step("urg", 4, 1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 1);
`endif
    step("urg", 5, 1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 0);
    step("urg", 6, 1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 0);
    step("urg", 7, 1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsbus_arbiter.md
Name: fsbus_arbiter

Overview:
- Wishbone arbiter sharing the external flash/SSRAM bus (one slave port) between NUM_MASTERS bus masters, e.g. the CPU and the VGA frame fetcher.
- Round-robin grant with a hold limit, so a streaming master cannot starve the others.
- Inserts one idle cycle between owners so the slave controller always sees a clean cycle boundary.
- Sits between the masters' Wishbone ports and the SSRAM/flash controller slave port.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4)
- AW, 32, address width
- MAX_HOLD, 16, number of acks a master may take before being forced off, when another master is waiting (1..255)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- m_cyc_i  in  NUM_MASTERS  per-master cycle request
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*AW  packed addresses; master i at [i*AW +: AW]
- m_sel_i  in  NUM_MASTERS*4  packed byte selects
- m_dat_i  in  NUM_MASTERS*32  packed write data
- m_urgent_i  in  NUM_MASTERS  urgent request flags; used only with ARB_URGENT_EN
- m_ack_o  out  NUM_MASTERS  per-master acknowledge
- m_dat_o  out  32  read data, broadcast to all masters (s_dat_i passthrough)
- s_cyc_o  out  1  slave-side cycle
- s_stb_o  out  1  slave-side strobe
- s_we_o  out  1  slave-side write enable
- s_adr_o  out  AW  slave-side address
- s_sel_o  out  4  slave-side byte selects
- s_dat_o  out  32  slave-side write data
- s_dat_i  in  32  slave read data
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  NUM_MASTERS  registered one-hot grant

Behaviour:
- Reset (synchronous, rst_i=1 at a clk_i edge):
  - state=IDLE, gnt_o=0, rr_ptr=0, hold_cnt=0.
  - All s_* outputs and m_ack_o are 0.
  - Reset mid-transfer abandons the transfer; no ack is delivered.
- States:
  - IDLE: s_cyc_o=0. If any m_cyc_i is high, the winner is the first requester at or after rr_ptr, searching cyclically. Register gnt_o=onehot(winner), hold_cnt=0, go to GRANT. Grant latency is 1 cycle from cyc assertion.
  - GRANT: s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_sel_o/s_dat_o mux combinationally from the granted master. s_cyc_o = m_cyc_i[g] and s_stb_o = m_stb_i[g].
  - GRANT: m_ack_o[g]=s_ack_i; all other m_ack_o bits are 0. hold_cnt increments on each s_ack_i, saturating at MAX_HOLD.
  - GRANT exit: leave when m_cyc_i[g] falls, or when hold_cnt==MAX_HOLD and another m_cyc_i is high. A forced exit takes effect only in the cycle after an s_ack_i, never mid-beat. On exit: gnt_o=0, rr_ptr=(g+1) mod NUM_MASTERS, go to HANDOFF.
  - HANDOFF: exactly one cycle with s_cyc_o=0 and s_stb_o=0, then IDLE. A new grant can therefore be registered at the end of the IDLE cycle. Minimum turnaround from one owner to the next is 2 cycles.
- Preempted master:
  - Its m_cyc_i stays high and it sees no ack, so it stalls transparently.
  - It is re-granted in rotation.
- hold_cnt with no other requester: hold_cnt==MAX_HOLD has no effect; the owner keeps the bus.
- Simultaneous requests: resolved by rr_ptr only. With ARB_URGENT_EN, resolved per the Optional Feature.
- Invariants:
  - gnt_o is always 0 or one-hot.
  - m_ack_o is never asserted for a master whose gnt_o bit is low.
  - s_ack_i arriving while gnt_o=0 is ignored.

Optional Feature:
- Macro: ARB_URGENT_EN.
- Defined:
  - In IDLE, any master with m_cyc_i & m_urgent_i wins over round-robin; the lowest index wins among urgent masters.
  - In GRANT, an urgent waiter counts as "another requester" for the hold limit regardless of MAX_HOLD; the owner is preempted after its next ack.
- Undefined: m_urgent_i is ignored and pure round-robin applies.

Decomposition:
- Package fsbus_pkg holds:
  - state enum {ARB_IDLE, ARB_GRANT, ARB_HANDOFF}
  - width constant for hold_cnt: $clog2(MAX_HOLD+1)
  - function for a cyclic one-hot priority pick (req, ptr) -> onehot
- One sub-module, rr_pick: combinational rotating priority encoder (req vector, ptr -> one-hot winner), reused by the optional urgent path with ptr=0.

Test Plan:
- Reset then single request: rst_i 1->0, m_cyc_i=2'b01 -> gnt_o=2'b01 one cycle later; s_adr_o=m_adr_i[0]; slave ack -> m_ack_o=2'b01.
- Simultaneous request after reset (rr_ptr=0), m_cyc_i=2'b11 -> master 0 granted. After master 0 drops cyc -> one cycle s_cyc_o=0, then gnt_o=2'b10 after the IDLE cycle.
- Hold limit, MAX_HOLD=4: master 0 streams with ack every cycle while master 1 waits -> exactly 4 acks to master 0, HANDOFF, then grant to master 1; master 0 saw no extra ack.
- Lone streamer: master 1 alone for 40 acks -> no handoff cycles, gnt_o stays 2'b10.
- Reset mid-beat: assert rst_i while GRANT with s_stb_o=1 and s_ack_i pending -> next cycle gnt_o=0, s_cyc_o=0, m_ack_o=0.
- ARB_URGENT_EN: master 0 streaming, master 1 raises cyc+urgent -> master 0 preempted after its next ack; master 1 granted 2 cycles later.
